// File: rtl/icicle_bus_pkg.sv
// Shared definitions for the common memory bus arbiter.
//   arb_state_t : arbiter FSM state (idle / transaction in flight)
//   BUS_AW      : slave bus address width
//   BUS_DW      : slave bus data width
//   BUS_MW      : slave bus byte-enable width
package icicle_bus_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_MW = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// The search starts one past the previous winner and wraps around, so the
// previous winner has the lowest priority.
// Ports:
//   i_req   [NREQ]  request vector
//   i_last  [LW]    index of the previous winner
//   o_grant [NREQ]  one-hot winner, 0 when no request is set
//   o_any           at least one request is set
module rr_pick #(
  parameter  int NREQ = 2,
  localparam int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [LW-1:0]   i_last,
  output logic [NREQ-1:0] o_grant,
  output logic            o_any
);

  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    // Offset 1 is the highest priority, offset NREQ (the last winner) the lowest.
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!o_any && i_req[i] && (i == (int'(i_last) + off) % NREQ)) begin
          o_grant[i] = 1'b1;
          o_any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the common memory bus between NREQ masters.
// One requester is granted at a time, round-robin, for exactly one transaction.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (hung slave accesses become faults
// after TIMEOUT BUSY cycles). Without it BUSY waits for ready_in indefinitely.
// Ports:
//   clk, reset (async, active low)
//   req_*_in            per-requester address/read/write/mask/data, slice i at [W*i +: W]
//   req_read_value_out  per-requester read data, nonzero only with its ready bit
//   req_ready_out       per-requester one-cycle completion
//   req_fault_out       per-requester one-cycle fault, always with ready
//   address_out, read_out, write_out, write_mask_out, write_value_out : slave bus
//   read_value_in, ready_in, fault_in : slave bus response
//   grant_out           one-hot current grant, 0 when idle
//   busy_out            transaction in flight (exposes the FSM state)
//
// Handshake: a master requests by raising its read or write strobe and holds
// every request field stable until its ready bit pulses for one cycle. The
// arbiter samples requests only in IDLE; ready_in/fault_in are honoured only
// in BUSY and are routed solely to the granted requester.
module mem_port_arbiter
  import icicle_bus_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ*BUS_AW-1:0]   req_address_in,
  input  logic [NREQ-1:0]          req_read_in,
  input  logic [NREQ-1:0]          req_write_in,
  input  logic [NREQ*BUS_MW-1:0]   req_write_mask_in,
  input  logic [NREQ*BUS_DW-1:0]   req_write_value_in,
  output logic [NREQ*BUS_DW-1:0]   req_read_value_out,
  output logic [NREQ-1:0]          req_ready_out,
  output logic [NREQ-1:0]          req_fault_out,
  output logic [BUS_AW-1:0]        address_out,
  output logic                     read_out,
  output logic                     write_out,
  output logic [BUS_MW-1:0]        write_mask_out,
  output logic [BUS_DW-1:0]        write_value_out,
  input  logic [BUS_DW-1:0]        read_value_in,
  input  logic                     ready_in,
  input  logic                     fault_in,
  output logic [NREQ-1:0]          grant_out,
  output logic                     busy_out
);

  localparam int            LW        = $clog2(NREQ);
  localparam logic [LW-1:0] LAST_INIT = LW'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_params
    $error("mem_port_arbiter: NREQ must be 2..8 and TIMEOUT must be >= 2");
  end

  arb_state_t      r_state;
  logic [NREQ-1:0] r_grant;
  logic [LW-1:0]   r_last;

  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_pick;
  logic            w_any;
  logic            w_busy;
  logic            w_req_g;
  logic            w_expire;
  logic            w_done_ok;
  logic            w_done_to;
  logic            w_abort;
  logic            w_complete;

  function automatic logic [LW-1:0] f_idx(input logic [NREQ-1:0] i_oh);
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i_oh[i]) v = LW'(i);
    end
    return v;
  endfunction

  assign w_req   = req_read_in | req_write_in;
  assign w_busy  = (r_state == ARB_BUSY);
  assign w_req_g = |(w_req & r_grant);

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] r_count;

  // Held at zero outside BUSY, so it starts from zero on every BUSY entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (r_state != ARB_BUSY) begin
      r_count <= '0;
    end else if (!ready_in) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign w_expire = (r_count == CW'(TIMEOUT - 1));
`else
  assign w_expire = 1'b0;
`endif

  // Priority in BUSY: slave ready, then withdrawal, then timeout.
  assign w_done_ok  = w_busy & ready_in;
  assign w_abort    = w_busy & ~ready_in & ~w_req_g;
  assign w_done_to  = w_busy & ~ready_in & w_req_g & w_expire;
  assign w_complete = w_done_ok | w_done_to;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_last  <= LAST_INIT;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state <= ARB_BUSY;
            r_grant <= w_pick;
          end
        end
        ARB_BUSY: begin
          if (w_complete || w_abort) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= f_idx(r_grant);
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign grant_out = r_grant;
  assign busy_out  = w_busy;

  // r_grant is zero outside BUSY, so the slave bus idles at all-zero.
  always_comb begin
    address_out     = '0;
    read_out        = 1'b0;
    write_out       = 1'b0;
    write_mask_out  = '0;
    write_value_out = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        address_out     = req_address_in[BUS_AW*i +: BUS_AW];
        read_out        = req_read_in[i];
        write_out       = req_write_in[i];
        write_mask_out  = req_write_mask_in[BUS_MW*i +: BUS_MW];
        write_value_out = req_write_value_in[BUS_DW*i +: BUS_DW];
      end
    end
  end

  always_comb begin
    req_ready_out      = '0;
    req_fault_out      = '0;
    req_read_value_out = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_out[i] = r_grant[i] & w_complete;
      req_fault_out[i] = r_grant[i] & ((w_done_ok & fault_in) | w_done_to);
      if (r_grant[i] && w_done_ok) begin
        req_read_value_out[BUS_DW*i +: BUS_DW] = read_value_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ*32-1:0]   req_address_in;
  logic [NREQ-1:0]      req_read_in;
  logic [NREQ-1:0]      req_write_in;
  logic [NREQ*4-1:0]    req_write_mask_in;
  logic [NREQ*32-1:0]   req_write_value_in;
  logic [NREQ*32-1:0]   req_read_value_out;
  logic [NREQ-1:0]      req_ready_out;
  logic [NREQ-1:0]      req_fault_out;
  logic [31:0]          address_out;
  logic                 read_out;
  logic                 write_out;
  logic [3:0]           write_mask_out;
  logic [31:0]          write_value_out;
  logic [31:0]          read_value_in;
  logic                 ready_in;
  logic                 fault_in;
  logic [NREQ-1:0]      grant_out;
  logic                 busy_out;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  mem_port_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk                (clk),
    .reset              (reset),
    .req_address_in     (req_address_in),
    .req_read_in        (req_read_in),
    .req_write_in       (req_write_in),
    .req_write_mask_in  (req_write_mask_in),
    .req_write_value_in (req_write_value_in),
    .req_read_value_out (req_read_value_out),
    .req_ready_out      (req_ready_out),
    .req_fault_out      (req_fault_out),
    .address_out        (address_out),
    .read_out           (read_out),
    .write_out          (write_out),
    .write_mask_out     (write_mask_out),
    .write_value_out    (write_value_out),
    .read_value_in      (read_value_in),
    .ready_in           (ready_in),
    .fault_in           (fault_in),
    .grant_out          (grant_out),
    .busy_out           (busy_out)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // checking helpers
  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] bus_vec();
    return {10'b0, address_out, read_out, write_out, write_mask_out, write_value_out};
  endfunction

  function automatic logic [79:0] mk_bus(input logic [31:0] a, input logic r, input logic w,
                                         input logic [3:0] m, input logic [31:0] d);
    return {10'b0, a, r, w, m, d};
  endfunction

  function automatic logic [NREQ*32-1:0] rv_slot(input int i, input logic [31:0] v);
    logic [NREQ*32-1:0] r;
    r = '0;
    r[32*i +: 32] = v;
    return r;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] d);
    req_read_in[i]              = rd;
    req_write_in[i]             = wr;
    req_address_in[32*i +: 32]  = a;
    req_write_mask_in[4*i +: 4] = m;
    req_write_value_in[32*i +: 32] = d;
  endtask

  task automatic drop(input int i);
    req_read_in[i]  = 1'b0;
    req_write_in[i] = 1'b0;
  endtask

  task automatic slave(input logic rdy, input logic flt, input logic [31:0] rv);
    ready_in      = rdy;
    fault_in      = flt;
    read_value_in = rv;
  endtask

  // reference model state for the random phase
  logic [NREQ-1:0] pend;
  logic [31:0]     m_addr[NREQ];
  logic            m_rd[NREQ];
  logic            m_wr[NREQ];
  logic [3:0]      m_mask[NREQ];
  logic [31:0]     m_data[NREQ];
  int              m_last, m_g, m_wait, n_busy;
  logic            m_busy, prev_rdy, m_flt, seen;
  logic [1:0]      t2_exp[3];
  logic [NREQ*32-1:0] exp_rv;

  initial begin
    req_read_in = '0; req_write_in = '0; req_address_in = '0;
    req_write_mask_in = '0; req_write_value_in = '0;
    slave(1'b0, 1'b0, 32'h0);

    // reset: outputs zero even with live inputs
    reset = 1'b0;
    repeat (2) step();
    slave(1'b1, 1'b1, 32'h1234_5678);
    set_req(0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
    settle();
    check("reset_grant", 80'(grant_out), 80'(0));
    check("reset_busy", 80'(busy_out), 80'(0));
    check("reset_bus", bus_vec(), 80'(0));
    check("reset_resp", 80'({req_ready_out, req_fault_out}), 80'(0));
    check("reset_rdata", 80'(req_read_value_out), 80'(0));
    step(); drop(0); slave(1'b0, 1'b0, 32'h0); reset = 1'b1;

    // 1: both request, requester 0 first, one idle cycle, then requester 1
    step();
    set_req(0, 1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h0000_2000, 4'hF, 32'h0);
    settle(); check("t1_idle_grant", 80'(grant_out), 80'(0));
    step(); settle();
    check("t1_grant0", 80'(grant_out), 80'(2'b01));
    check("t1_bus0", bus_vec(), mk_bus(32'h0000_1000, 1'b1, 1'b0, 4'hF, 32'h0));
    check("t1_wait_noready", 80'(req_ready_out), 80'(0));
    step(); slave(1'b1, 1'b0, 32'hA5A5_0001); settle();
    check("t1_ready0", 80'({req_ready_out, req_fault_out}), 80'({2'b01, 2'b00}));
    check("t1_rdata0", 80'(req_read_value_out), 80'(rv_slot(0, 32'hA5A5_0001)));
    step(); slave(1'b0, 1'b0, 32'h0); drop(0); settle();
    check("t1_gap", 80'({grant_out, busy_out}), 80'(0));
    step(); settle();
    check("t1_grant1", 80'(grant_out), 80'(2'b10));
    check("t1_bus1", bus_vec(), mk_bus(32'h0000_2000, 1'b1, 1'b0, 4'hF, 32'h0));
    step(); slave(1'b1, 1'b0, 32'h5A5A_0002); settle();
    check("t1_ready1", 80'(req_ready_out), 80'(2'b10));
    check("t1_rdata1", 80'(req_read_value_out), 80'(rv_slot(1, 32'h5A5A_0002)));
    step(); slave(1'b0, 1'b0, 32'h0); drop(1);

    // 2: requester 0 continuous, requester 1 once -> 0,1,0
    t2_exp[0] = 2'b01; t2_exp[1] = 2'b10; t2_exp[2] = 2'b01;
    step();
    set_req(0, 1'b1, 1'b0, 32'h0000_0400, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h0000_0800, 4'hF, 32'h0);
    slave(1'b1, 1'b0, 32'hC0DE_0000);
    settle();
    for (int k = 0; k < 3; k++) begin
      step(); settle();
      check("t2_grant", 80'(grant_out), 80'(t2_exp[k]));
      check("t2_ready", 80'(req_ready_out), 80'(t2_exp[k]));
      step();
      if (k == 1) drop(1);
      if (k == 2) drop(0);
      settle();
      check("t2_gap_busy", 80'(busy_out), 80'(0));
    end
    slave(1'b0, 1'b0, 32'h0);

    // 3: write through requester 1, visible on the bus for exactly one cycle
    step();
    set_req(0, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF);
    set_req(1, 1'b0, 1'b1, 32'h0001_0000, 4'b0001, 32'hDEAD_BEEF);
    settle(); check("t3_idle_bus", bus_vec(), 80'(0));
    step(); slave(1'b1, 1'b0, 32'h7777_7777); settle();
    check("t3_bus", bus_vec(), mk_bus(32'h0001_0000, 1'b0, 1'b1, 4'b0001, 32'hDEAD_BEEF));
    check("t3_ready", 80'({req_ready_out, req_fault_out}), 80'({2'b10, 2'b00}));
    check("t3_r0_quiet", 80'(req_read_value_out[31:0]), 80'(0));
    step(); drop(1); slave(1'b0, 1'b0, 32'h0); settle();
    check("t3_one_cycle", bus_vec(), 80'(0));
    check("t3_ready_gone", 80'(req_ready_out), 80'(0));

    // 4: decode miss -> fault with ready; slave signals ignored while idle
    step();
    slave(1'b1, 1'b1, 32'hBAD0_BAD0);
    set_req(0, 1'b1, 1'b0, 32'h0004_0000, 4'hF, 32'h0);
    settle(); check("t4_idle_ignore", 80'({req_ready_out, req_fault_out}), 80'(0));
    step(); settle();
    check("t4_fault", 80'({req_ready_out, req_fault_out}), 80'({2'b01, 2'b01}));
    step(); drop(0); slave(1'b0, 1'b0, 32'h0); settle();
    check("t4_fault_one_cycle", 80'({req_ready_out, req_fault_out}), 80'(0));

    // 6: reset in BUSY aborts; afterwards requester 0 wins first
    step(); set_req(1, 1'b1, 1'b0, 32'h0000_3000, 4'hF, 32'h0);
    step(); settle();
    check("t6_busy_r1", 80'(grant_out), 80'(2'b10));
    #1;
    reset = 1'b0;
    slave(1'b1, 1'b1, 32'hFACE_0000);
    set_req(0, 1'b1, 1'b0, 32'h0000_3100, 4'hF, 32'h0);
    #1;
    check("t6_async_grant", 80'({grant_out, busy_out}), 80'(0));
    check("t6_async_bus", bus_vec(), 80'(0));
    check("t6_async_resp", 80'({req_ready_out, req_fault_out}), 80'(0));
    check("t6_async_rdata", 80'(req_read_value_out), 80'(0));
    step(); settle();
    check("t6_hold", 80'({grant_out, busy_out, req_ready_out}), 80'(0));
    step(); reset = 1'b1; slave(1'b1, 1'b0, 32'h600D_0000); settle();
    check("t6_release_idle", 80'(grant_out), 80'(0));
    step(); settle();
    check("t6_first_r0", 80'({grant_out, req_ready_out}), 80'({2'b01, 2'b01}));
    step(); drop(0); settle();
    check("t6_gap", 80'(busy_out), 80'(0));
    step(); settle();
    check("t6_then_r1", 80'({grant_out, req_ready_out}), 80'({2'b10, 2'b10}));
    step(); drop(1); slave(1'b0, 1'b0, 32'h0);

    // 5: slave never readies
    step();
    set_req(1, 1'b1, 1'b0, 32'h0000_5000, 4'hF, 32'h0);
    slave(1'b0, 1'b0, 32'hFFFF_0000);
    n_busy = 0; seen = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      step(); settle();
      n_busy = k;
      if (req_ready_out != '0) begin
        seen = 1'b1;
        break;
      end
    end
`ifdef MEM_ARB_TIMEOUT_EN
    check("t5_expire_cycle", 80'(n_busy), 80'(TIMEOUT));
    check("t5_fault", 80'({req_ready_out, req_fault_out}), 80'({2'b10, 2'b10}));
    check("t5_rdata_zero", 80'(req_read_value_out), 80'(0));
    step(); drop(1); settle();
    check("t5_after", 80'(busy_out), 80'(0));
`else
    check("t5_no_expire", 80'(seen), 80'(0));
    check("t5_still_busy", 80'({grant_out, busy_out}), 80'({2'b10, 1'b1}));
    step(); slave(1'b1, 1'b0, 32'h0BAD_F00D); settle();
    check("t5_late_ready", 80'({req_ready_out, req_fault_out}), 80'({2'b10, 2'b00}));
    step(); drop(1);
`endif
    slave(1'b0, 1'b0, 32'h0);

    // random traffic against the transaction-level model
    pend = '0; m_last = 1; m_busy = 1'b0; m_g = 0; m_wait = 0; prev_rdy = 1'b0; m_flt = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      m_addr[i] = '0; m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_mask[i] = '0; m_data[i] = '0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step();
      if (m_busy) begin
        if (prev_rdy) begin
          pend[m_g] = 1'b0;
          drop(m_g);
          m_last = m_g;
          m_busy = 1'b0;
        end
      end else begin
        for (int off = 1; off <= NREQ; off++) begin
          if (!m_busy && pend[(m_last + off) % NREQ]) begin
            m_busy = 1'b1;
            m_g    = (m_last + off) % NREQ;
            m_wait = int'($urandom_range(0, 3));
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          m_rd[i]   = 1'($urandom_range(0, 1));
          m_wr[i]   = !m_rd[i];
          m_addr[i] = $urandom;
          m_mask[i] = 4'($urandom_range(0, 15));
          m_data[i] = $urandom;
          set_req(i, m_rd[i], m_wr[i], m_addr[i], m_mask[i], m_data[i]);
        end
      end
      prev_rdy = 1'b0;
      if (m_busy && m_wait == 0) begin
        m_flt    = ($urandom_range(0, 3) == 0);
        prev_rdy = 1'b1;
        slave(1'b1, m_flt, $urandom);
        exp_q.push_back(read_value_in);
      end else if (m_busy) begin
        m_wait--;
        slave(1'b0, 1'($urandom_range(0, 1)), $urandom);
      end else begin
        slave(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end
      settle();
      check("rand_grant", 80'({grant_out, busy_out}),
            80'({(m_busy ? NREQ'(1 << m_g) : NREQ'(0)), m_busy}));
      check("rand_bus", bus_vec(),
            m_busy ? mk_bus(m_addr[m_g], m_rd[m_g], m_wr[m_g], m_mask[m_g], m_data[m_g]) : 80'(0));
      check("rand_resp", 80'({req_ready_out, req_fault_out}),
            80'({(prev_rdy ? NREQ'(1 << m_g) : NREQ'(0)), ((prev_rdy && m_flt) ? NREQ'(1 << m_g) : NREQ'(0))}));
      exp_rv = '0;
      if (req_ready_out != '0) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_ready", 80'(req_ready_out), 80'(0));
        end else begin
          exp_rv = rv_slot(m_g, exp_q.pop_front());
        end
      end
      check("rand_rdata", 80'(req_read_value_out), 80'(exp_rv));
    end
    check("rand_sb_empty", 80'(exp_q.size()), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
